// File: rtl/hw_pkg.sv
// rtl/hw_pkg.sv - shared types for the contact debouncer
package hw_pkg;

  typedef enum logic {DB_STABLE, DB_PEND} db_state_t;

endpackage

// File: rtl/contact_debounce_ch.sv
// rtl/contact_debounce_ch.sv - one debounce channel: synchronizer, qualify FSM, tick counter, held strobe
module contact_debounce_ch
  import hw_pkg::*;
#(
  parameter int   D    = 10,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = $clog2(D + 1);
  localparam logic [CW-1:0] CTR_LOAD = CW'(D);
  localparam logic [CW-1:0] CTR_ONE  = CW'(1);

  logic          meta;
  logic          sync;
  db_state_t     state, state_nx;
  logic [CW-1:0] ctr, ctr_nx;
  logic          level_nx, rise_nx, fall_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= INIT;
      sync  <= INIT;
      state <= DB_STABLE;
      ctr   <= CTR_LOAD;
      level <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      state <= state_nx;
      ctr   <= ctr_nx;
      level <= level_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ctr_nx   = ctr;
    level_nx = level;
    rise_nx  = rise;
    fall_nx  = fall;
    // A held strobe has now been visible across one tick; a commit below overrides this.
    if (tick) begin
      rise_nx = 1'b0;
      fall_nx = 1'b0;
    end
    case (state)
      DB_STABLE: begin
        if (sync != level) begin
          state_nx = DB_PEND;
          ctr_nx   = CTR_LOAD;
        end
      end
      DB_PEND: begin
        if (sync == level) begin
          state_nx = DB_STABLE;
        end else if (tick) begin
          if (ctr == CTR_ONE) begin
            level_nx = ~level;
            rise_nx  = ~level;
            fall_nx  = level;
            state_nx = DB_STABLE;
          end else begin
            ctr_nx = ctr - CTR_ONE;
          end
        end
      end
      default: state_nx = DB_STABLE;
    endcase
  end

endmodule

// File: rtl/contact_debounce.sv
// rtl/contact_debounce.sv - N independent contact debounce channels sharing clk, rst and tick
module contact_debounce #(
  parameter int   N    = 1,
  parameter int   D    = 10,
  parameter logic INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    contact_debounce_ch #(
      .D    (D),
      .INIT (INIT)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (raw[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: doc/contact_debounce.md
# contact_debounce

Multi-channel contact debouncer for front-panel switches and electromechanical I/O contacts, such as typewriter and tape-reader contacts. It sits directly upstream of the tick-timed single-shots. Each raw asynchronous input is synchronized to clk and qualified for D stable ticks before its debounced level changes. Each committed change produces a rise or fall strobe that is held until the next tick, so a tick-sampled single-shot trigger input always catches it.

## Interface
- N, 1: number of independent channels.
- D, 10: required stable duration in ticks; legal range D ≥ 1.
- INIT, 1'b0: reset value of every channel's synchronizer and debounced level.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high. Clock is clk.
- tick  in  1  one-clk timebase strobe, shared with downstream single-shots.
- raw  in  N  asynchronous contact inputs.
- level  out  N  debounced level per channel.
- rise  out  N  rising-edge strobe per channel, tick-aligned.
- fall  out  N  falling-edge strobe per channel, tick-aligned.

## Operation
- Each channel has its own 2-FF synchronizer. `sync` is the output of the second flop.
- Each channel runs a two-state FSM:
  - **STABLE**: if `sync != level`, go to PEND and load `ctr = D`.
  - **PEND**, evaluated every clk:
    - If `sync == level`, abort to STABLE. No strobe, level unchanged.
    - Else if `tick` is high: if `ctr == 1`, commit. Otherwise decrement `ctr`.
- Commit actions:
  - `level <= ~level`.
  - Set `rise` if the new level is 1, or `fall` if it is 0.
  - Return to STABLE.
- Strobe hold:
  - A set `rise`/`fall` stays high through the first subsequent cycle with `tick` high, then clears on the following clk.
  - The strobe is never high for zero ticks.
- Counter width is `$clog2(D+1)`. The counter never wraps: it is reloaded on PEND entry and only decremented while > 1.
- Channels are fully independent. They share only clk, rst and tick.

## Timing
- Reset values:
  - `level = INIT`, `rise = 0`, `fall = 0`.
  - Synchronizers = INIT, FSM = STABLE, `ctr = D`.
- Reset mid-PEND discards the pending change; no strobe is emitted. Reset while a strobe is held clears it immediately.
- Latency:
  - raw edge → `sync`: 2 clk.
  - `sync` → PEND: +1 clk.
  - PEND → commit: on the D-th tick seen while in PEND, excluding a tick in the entry cycle.
  - `level`/`rise`/`fall` update in the clk after the committing tick.
  - Effective stability window: between D−1 and D tick periods.
- Simultaneous events:
  - An abort (`sync` revert) in the same cycle as `tick` wins: no decrement, no commit.
  - A tick in the cycle `sync` first differs does not count.
- Strobe timing: the strobe is set in cycle c+1 after a committing tick at c. It stays high up to and including the next tick cycle t′, and clears at t′+1.
- D = 1 boundary: an opposite commit may occur at t′. The old strobe clears at t′+1 while the new strobe sets at t′+1, so rise and fall are never high together.

## Structure
- Shared package `hw_pkg`: `typedef enum logic {DB_STABLE, DB_PEND} db_state_t;`.
- One sub-module, `contact_debounce_ch`, holds one channel: synchronizer, FSM, counter and strobe-hold flop.
- The top level instantiates N copies in a generate loop and concatenates the outputs.
- Target size is about 150 RTL lines in total.

## Test plan
- **Clean step**, D=4, tick every 8 clk: raw 0→1 held high. Expect level=1 and rise=1 one clk after the 4th tick following PEND entry. Rise is held until the next tick and fall stays 0 throughout.
- **Bounce**, D=4: raw high for 2 ticks, then low. Expect abort, level stays 0 and no strobes. A subsequent 4-tick high commits normally.
- **Revert on tick**: `sync` returns to level in exactly the cycle `tick` is high with ctr=1. Expect no commit and no strobe.
- **Reset mid-operation**: rst pulsed while in PEND with ctr=2, and separately while rise is held. Expect level=INIT and rise=fall=0 on the next clk, with no later strobe.
- **N=3 independence**: different bounce patterns per channel. Each channel's commits and strobes match a per-channel reference model, with no cross-coupling.
- **D=1 back-to-back**: raw toggles so that rise and fall commit on consecutive ticks. Expect rise and fall never high simultaneously, and each is high across exactly one tick cycle.
